// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: one outstanding I-cache request, same-cycle branch
// prediction query on the response, and a small fetch queue feeding decode.
module fetch_pc_gen #(
    parameter int FQ_DEPTH  = 4,
    parameter int OBQ_IDX_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 mem_req_valid,
    output logic [31:0]          mem_req_pc,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_inst,
    input  logic                 mem_rsp_is_branch,
    output logic                 bp_if_branch,
    output logic [31:0]          bp_if_pc,
    input  logic                 bp_next_pc_valid,
    input  logic [31:0]          bp_next_pc,
    input  logic [OBQ_IDX_W-1:0] bp_next_pc_index,
    input  logic                 rt_redirect,
    input  logic [31:0]          rt_redirect_pc,
    output logic                 fq_valid,
    output logic [31:0]          fq_pc,
    output logic [31:0]          fq_inst,
    output logic [31:0]          fq_npc,
    output logic                 fq_pred_taken,
    output logic [OBQ_IDX_W-1:0] fq_obq_idx,
    input  logic                 id_ready
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;

    logic [31:0]            r_fq_pc    [FQ_DEPTH];
    logic [31:0]            r_fq_inst  [FQ_DEPTH];
    logic [31:0]            r_fq_npc   [FQ_DEPTH];
    logic                   r_fq_taken [FQ_DEPTH];
    logic [OBQ_IDX_W-1:0]   r_fq_idx   [FQ_DEPTH];

    logic                   w_full;
    logic                   w_empty;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_bp_query;
    logic                   w_taken;
    logic [31:0]            w_npc;
    logic [OBQ_IDX_W-1:0]   w_idx;

    assign w_full      = (r_count == CNT_W'(FQ_DEPTH));
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_issue     = (r_state == S_FETCH) && enable && !w_full && !rt_redirect;
    // A redirect kills both the response being captured and any pop by decode.
    assign w_push      = (r_state == S_WAIT) && mem_rsp_valid && !rt_redirect;
    assign w_pop       = !w_empty && id_ready && !rt_redirect;
    assign w_bp_query  = w_push && mem_rsp_is_branch;
    assign w_taken     = w_bp_query && bp_next_pc_valid;
    assign w_npc       = w_taken ? bp_next_pc : (r_pc + 32'd4);
    assign w_idx       = w_bp_query ? bp_next_pc_index : {OBQ_IDX_W{1'b0}};
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; redirect overrides every state
    always_comb begin
        w_state_nxt = r_state;
        if (rt_redirect) begin
            if (((r_state == S_WAIT) || (r_state == S_DROP)) && !mem_rsp_valid) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_issue) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (!mem_rsp_valid) begin
                        w_state_nxt = S_WAIT;
                    end else if (w_count_nxt == CNT_W'(FQ_DEPTH)) begin
                        w_state_nxt = S_FULL;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_FULL;
                    end
                end
                S_DROP: begin
                    if (mem_rsp_valid) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

    // FSM outputs and queue head; everything reads zero while reset is held
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_pc    = 32'd0;
        bp_if_branch  = 1'b0;
        bp_if_pc      = 32'd0;
        fq_valid      = 1'b0;
        fq_pc         = 32'd0;
        fq_inst       = 32'd0;
        fq_npc        = 32'd0;
        fq_pred_taken = 1'b0;
        fq_obq_idx    = {OBQ_IDX_W{1'b0}};
        if (!reset) begin
            mem_req_valid = w_issue;
            mem_req_pc    = r_pc;
            bp_if_branch  = w_bp_query;
            bp_if_pc      = r_pc;
            fq_valid      = !w_empty;
            fq_pc         = r_fq_pc[r_head];
            fq_inst       = r_fq_inst[r_head];
            fq_npc        = r_fq_npc[r_head];
            fq_pred_taken = r_fq_taken[r_head];
            fq_obq_idx    = r_fq_idx[r_head];
        end else begin
            mem_req_valid = 1'b0;
            bp_if_branch  = 1'b0;
        end
    end

    // PC and queue pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= 32'd0;
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (rt_redirect) begin
            r_pc    <= rt_redirect_pc;
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_pc   <= w_npc;
                r_tail <= r_tail + PTR_W'(1);
            end else begin
                r_pc   <= r_pc;
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end else begin
                r_head <= r_head;
            end
            r_count <= w_count_nxt;
        end
    end

    // Queue storage, written at the tail on each accepted response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_fq_pc[i]    <= 32'd0;
                r_fq_inst[i]  <= 32'd0;
                r_fq_npc[i]   <= 32'd0;
                r_fq_taken[i] <= 1'b0;
                r_fq_idx[i]   <= {OBQ_IDX_W{1'b0}};
            end
        end else if (w_push) begin
            r_fq_pc[r_tail]    <= r_pc;
            r_fq_inst[r_tail]  <= mem_rsp_inst;
            r_fq_npc[r_tail]   <= w_npc;
            r_fq_taken[r_tail] <= w_taken;
            r_fq_idx[r_tail]   <= w_idx;
        end else begin
            r_fq_pc[r_tail]    <= r_fq_pc[r_tail];
            r_fq_inst[r_tail]  <= r_fq_inst[r_tail];
            r_fq_npc[r_tail]   <= r_fq_npc[r_tail];
            r_fq_taken[r_tail] <= r_fq_taken[r_tail];
            r_fq_idx[r_tail]   <= r_fq_idx[r_tail];
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: queue-based reference model checked every
// cycle, plus literal expectations pinning key entries and request addresses.
module tb_fetch_pc_gen;

    localparam int FQ_DEPTH  = 4;
    localparam int OBQ_IDX_W = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 mem_req_valid;
    logic [31:0]          mem_req_pc;
    logic                 mem_rsp_valid;
    logic [31:0]          mem_rsp_inst;
    logic                 mem_rsp_is_branch;
    logic                 bp_if_branch;
    logic [31:0]          bp_if_pc;
    logic                 bp_next_pc_valid;
    logic [31:0]          bp_next_pc;
    logic [OBQ_IDX_W-1:0] bp_next_pc_index;
    logic                 rt_redirect;
    logic [31:0]          rt_redirect_pc;
    logic                 fq_valid;
    logic [31:0]          fq_pc;
    logic [31:0]          fq_inst;
    logic [31:0]          fq_npc;
    logic                 fq_pred_taken;
    logic [OBQ_IDX_W-1:0] fq_obq_idx;
    logic                 id_ready;

    fetch_pc_gen #(.FQ_DEPTH(FQ_DEPTH), .OBQ_IDX_W(OBQ_IDX_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .mem_req_valid(mem_req_valid), .mem_req_pc(mem_req_pc),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_inst(mem_rsp_inst),
        .mem_rsp_is_branch(mem_rsp_is_branch),
        .bp_if_branch(bp_if_branch), .bp_if_pc(bp_if_pc),
        .bp_next_pc_valid(bp_next_pc_valid), .bp_next_pc(bp_next_pc),
        .bp_next_pc_index(bp_next_pc_index),
        .rt_redirect(rt_redirect), .rt_redirect_pc(rt_redirect_pc),
        .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_inst(fq_inst), .fq_npc(fq_npc),
        .fq_pred_taken(fq_pred_taken), .fq_obq_idx(fq_obq_idx),
        .id_ready(id_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          npc;
        logic                 taken;
        logic [OBQ_IDX_W-1:0] idx;
    } ent_t;

    ent_t        m_q[$];
    ent_t        push_log[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_drop;
    bit          pend;
    int          cnt;
    int          mem_lat;
    logic [31:0] pend_pc;
    int          checks;
    int          errors;
    logic        s_req;
    logic [31:0] s_req_pc;
    logic        s_fqv;
    bit          e_req;
    bit          e_bpb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Branch predictor / predecode table seen by the bench memory
    function automatic void bp_lookup(input logic [31:0] pc, output bit br, output bit v,
                                      output logic [31:0] tgt, output logic [OBQ_IDX_W-1:0] idx);
        br  = 1'b0;
        v   = 1'b1;
        tgt = 32'hDEAD_BEEC;
        idx = 5'd7;
        if (pc == 32'h0000_0030) begin
            br = 1'b1; v = 1'b1; tgt = 32'h0000_0090; idx = 5'd3;
        end else if (pc == 32'h0000_0040) begin
            br = 1'b1; v = 1'b0; tgt = 32'h1234_5678; idx = 5'd4;
        end else if (pc == 32'h0000_0208) begin
            br = 1'b1; v = 1'b1; tgt = 32'hFFFF_FFFC; idx = 5'd9;
        end
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'd0;
        m_busy = 1'b0;
        m_drop = 1'b0;
        pend   = 1'b0;
        cnt    = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_valid"}, mem_req_valid, 32'd0);
        chk({tag, "_req_pc"}, mem_req_pc, 32'd0);
        chk({tag, "_bp_branch"}, bp_if_branch, 32'd0);
        chk({tag, "_bp_pc"}, bp_if_pc, 32'd0);
        chk({tag, "_fq_valid"}, fq_valid, 32'd0);
        chk({tag, "_fq_pc"}, fq_pc, 32'd0);
        chk({tag, "_fq_inst"}, fq_inst, 32'd0);
        chk({tag, "_fq_npc"}, fq_npc, 32'd0);
        chk({tag, "_fq_taken"}, fq_pred_taken, 32'd0);
        chk({tag, "_fq_idx"}, fq_obq_idx, 32'd0);
    endtask

    // One clock: drive at negedge, compare against the model, advance the model at posedge
    task automatic cycle(input bit en, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit                   br;
        bit                   v;
        logic [31:0]          tgt;
        logic [OBQ_IDX_W-1:0] bidx;
        bit                   pop;
        ent_t                 e;
        @(negedge clock);
        enable = en; id_ready = rdy; rt_redirect = rd; rt_redirect_pc = rpc;
        mem_rsp_valid = 1'b0; mem_rsp_inst = 32'd0; mem_rsp_is_branch = 1'b0;
        bp_next_pc_valid = 1'b0; bp_next_pc = 32'd0; bp_next_pc_index = 5'd0;
        if (pend && cnt == 1) begin
            bp_lookup(pend_pc, br, v, tgt, bidx);
            mem_rsp_valid     = 1'b1;
            mem_rsp_inst      = pend_pc ^ 32'hA5A5_0F0F;
            mem_rsp_is_branch = br;
            bp_next_pc_valid  = v;
            bp_next_pc        = tgt;
            bp_next_pc_index  = bidx;
        end
        #1;
        e_req = en && !m_busy && (m_q.size() < FQ_DEPTH) && !rd;
        e_bpb = m_busy && !m_drop && mem_rsp_valid && mem_rsp_is_branch && !rd;
        chk("req_valid", mem_req_valid, e_req);
        if (e_req) chk("req_pc", mem_req_pc, m_pc);
        chk("bp_if_branch", bp_if_branch, e_bpb);
        chk("bp_if_pc", bp_if_pc, m_pc);
        chk("fq_valid", fq_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("fq_pc", fq_pc, m_q[0].pc);
            chk("fq_inst", fq_inst, m_q[0].inst);
            chk("fq_npc", fq_npc, m_q[0].npc);
            chk("fq_taken", fq_pred_taken, m_q[0].taken);
            chk("fq_idx", fq_obq_idx, m_q[0].idx);
        end
        s_req = mem_req_valid; s_req_pc = mem_req_pc; s_fqv = fq_valid;
        @(posedge clock);
        pop = (m_q.size() != 0) && rdy;
        if (rd) begin
            m_q.delete();
            if (m_busy && !mem_rsp_valid) begin
                m_drop = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            m_pc = rpc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && mem_rsp_valid) begin
                if (!m_drop) begin
                    e.pc    = m_pc;
                    e.inst  = mem_rsp_inst;
                    e.taken = e_bpb && bp_next_pc_valid;
                    e.npc   = e.taken ? bp_next_pc : m_pc + 32'd4;
                    e.idx   = e_bpb ? bp_next_pc_index : 5'd0;
                    m_q.push_back(e);
                    push_log.push_back(e);
                    m_pc = e.npc;
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (e_req) begin
                m_busy = 1'b1;
            end
        end
        if (pend) begin
            if (cnt == 1) pend = 1'b0;
            else cnt--;
        end
        if (s_req) begin
            pend = 1'b1; cnt = mem_lat; pend_pc = s_req_pc;
        end
    endtask

    task automatic wait_req(input bit rdy, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1'b1, rdy, 1'b0, 32'd0);
            seen = s_req;
        end
        chk({tag, "_req_seen"}, seen, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;
        checks = 0; errors = 0; mem_lat = 1;
        model_reset();
        reset = 1'b1; enable = 1'b1; id_ready = 1'b1; rt_redirect = 1'b0; rt_redirect_pc = 32'd0;
        mem_rsp_valid = 1'b0; mem_rsp_inst = 32'd0; mem_rsp_is_branch = 1'b0;
        bp_next_pc_valid = 1'b0; bp_next_pc = 32'd0; bp_next_pc_index = 5'd0;
        repeat (2) @(negedge clock);
        #1;
        chk_zero("rst");
        @(negedge clock);
        enable = 1'b0; id_ready = 1'b0;
        reset = 1'b0;

        // Sequential fetch, then taken branch at 0x30
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (40) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("seq_push_count", push_log.size() >= 14, 32'd1);
        if (push_log.size() >= 14) begin
            chk("seq0_pc", push_log[0].pc, 32'h0);
            chk("seq0_npc", push_log[0].npc, 32'h4);
            chk("seq0_taken", push_log[0].taken, 32'd0);
            chk("seq1_pc", push_log[1].pc, 32'h4);
            chk("br30_pc", push_log[12].pc, 32'h30);
            chk("br30_npc", push_log[12].npc, 32'h90);
            chk("br30_taken", push_log[12].taken, 32'd1);
            chk("br30_idx", push_log[12].idx, 32'd3);
            chk("after_br_pc", push_log[13].pc, 32'h90);
        end

        // Not-taken branch at 0x40 reached through a redirect
        n = push_log.size();
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir40_fq_empty", s_fqv, 32'd0);
        chk("redir40_req", s_req, 32'd1);
        chk("redir40_req_pc", s_req_pc, 32'h40);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("br40_pc", push_log[n].pc, 32'h40);
        chk("br40_npc", push_log[n].npc, 32'h44);
        chk("br40_taken", push_log[n].taken, 32'd0);
        chk("br40_idx", push_log[n].idx, 32'd4);
        chk("br40_next", push_log[n+1].pc, 32'h44);

        // Fill the queue with decode stalled, then release one entry
        n = push_log.size();
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("full_no_req", s_req, 32'd0);
        chk("full_fq_valid", s_fqv, 32'd1);
        chk("full_model_cnt", m_q.size(), 32'd4);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("pop_cycle_no_req", s_req, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("req_after_pop", s_req, 32'd1);
        chk("req_after_pop_pc", s_req_pc, 32'h10);
        repeat (16) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) chk("full_seq_pc", push_log[n+k].pc, 32'(4 * k));

        // Redirect while waiting; the late response must be dropped
        mem_lat = 3;
        wait_req(1'b1, "drop");
        n = push_log.size();
        mem_lat = 1;
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("drop_fq_empty", s_fqv, 32'd0);
        chk("drop_no_req", s_req, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("drop_rsp_no_req", s_req, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("drop_req", s_req, 32'd1);
        chk("drop_req_pc", s_req_pc, 32'h200);
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("drop_first_push", push_log[n].pc, 32'h200);
        chk("br208_npc", push_log[n+2].npc, 32'hFFFF_FFFC);
        chk("br208_idx", push_log[n+2].idx, 32'd9);
        chk("wrap_pc", push_log[n+3].pc, 32'hFFFF_FFFC);
        chk("wrap_npc", push_log[n+3].npc, 32'h0);

        // Redirect coincident with a response and a pop
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'd0);
            ok = s_req && (m_q.size() >= 1);
        end
        chk("coinc_setup", ok, 32'd1);
        n = push_log.size();
        cycle(1'b1, 1'b1, 1'b1, 32'h300);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("coinc_fq_empty", s_fqv, 32'd0);
        chk("coinc_req", s_req, 32'd1);
        chk("coinc_req_pc", s_req_pc, 32'h300);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("coinc_first_push", push_log[n].pc, 32'h300);

        // Reset in the middle of a wait
        mem_lat = 3;
        wait_req(1'b1, "rstmid");
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_zero("rstmid");
        model_reset();
        @(negedge clock);
        enable = 1'b0; id_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_is_branch = 1'b0;
        reset = 1'b0;
        mem_lat = 1;
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rstmid_req", s_req, 32'd1);
        chk("rstmid_req_pc", s_req_pc, 32'h0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
